// File: rtl/shifter_pkg.sv
// Shared constants and encodings for the iterative shift unit.
package shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of a shift/rotate: moves value by 1 or 2 bit positions.
module shift_step #(
    parameter int WIDTH = shifter_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    input  logic             two,
    output logic [WIDTH-1:0] stepped
);
    import shifter_pkg::*;

    logic fill;

    // Bit entering at the top for non-rotating right shifts: sign for SRA, zero for SRL.
    assign fill = (op == OP_SRA) & value[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic l1, l2, r1, r2;

            if (gi >= 1) begin : g_l1
                assign l1 = value[gi-1];
            end else begin : g_l1_zero
                assign l1 = 1'b0;
            end

            if (gi >= 2) begin : g_l2
                assign l2 = value[gi-2];
            end else begin : g_l2_zero
                assign l2 = 1'b0;
            end

            if (gi + 1 < WIDTH) begin : g_r1
                assign r1 = value[gi+1];
            end else begin : g_r1_top
                assign r1 = (op == OP_ROR) ? value[gi+1-WIDTH] : fill;
            end

            if (gi + 2 < WIDTH) begin : g_r2
                assign r2 = value[gi+2];
            end else begin : g_r2_top
                assign r2 = (op == OP_ROR) ? value[gi+2-WIDTH] : fill;
            end

            assign stepped[gi] = (op == OP_SLL) ? (two ? l2 : l1) : (two ? r2 : r1);
        end
    endgenerate

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: up to two bit positions per cycle, valid/ready on both sides.
module iterative_shifter #(
    parameter int WIDTH   = shifter_pkg::WIDTH,
    parameter int SHAMT_W = shifter_pkg::SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);
    import shifter_pkg::*;

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic [SHAMT_W-1:0] remaining_reg, remaining_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   stepped;
    logic               two;

    assign two = (remaining_reg > SHAMT_W'(1));

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value   (result_reg),
        .op      (op_reg),
        .two     (two),
        .stepped (stepped)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            result_reg    <= '0;
            remaining_reg <= '0;
            op_reg        <= OP_SLL;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            remaining_reg <= remaining_next;
            op_reg        <= op_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        result_next    = result_reg;
        remaining_next = remaining_reg;
        op_next        = op_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    result_next    = operand;
                    remaining_next = shamt;
                    op_next        = op;
                    state_next     = (shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A zero count here cannot arise from IDLE, but must not trap the FSM.
                if (remaining_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    result_next    = stepped;
                    remaining_next = remaining_reg - (two ? SHAMT_W'(2) : SHAMT_W'(1));
                    if (remaining_next == '0)
                        state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign result    = result_reg;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed-table, hand-sequence and random-sweep checks of the iterative shift unit.
module tb_iterative_shifter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    iterative_shifter dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        int k;
        k = 32 - int'(s);
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return (s == 5'd0) ? a : ((a >> s) | (a << k));
        endcase
    endfunction

    // Issues one request from IDLE (called at posedge+#1), waits for the result, stalls, then hands it off.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                          input int stall, output logic [31:0] res, output int lat);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        operand  = a;
        shamt    = s;
        out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        operand  = $urandom;
        shamt    = 5'($urandom);
        op       = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        res = result;
        repeat (stall) begin
            @(posedge clock); #1;
        end
        if (stall > 0) begin
            check("hold_result", result, res);
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("in_ready_after", 32'(in_ready), 32'd1);
        $display("op=%0d a=%h s=%0d result=%h lat=%0d", o, a, s, res, lat);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [4:0]  rs;

        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, 4};
        vecs[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 17};
        vecs[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 17};
        vecs[3]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2};
        vecs[4]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[5]  = '{2'b10, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF, 3};
        vecs[6]  = '{2'b11, 32'h1234_5678, 5'd4,  32'h8123_4567, 3};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 17};
        vecs[8]  = '{2'b11, 32'h8000_0001, 5'd2,  32'h6000_0000, 2};
        vecs[9]  = '{2'b01, 32'hF0F0_F0F0, 5'd6,  32'h03C3_C3C3, 4};
        vecs[10] = '{2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000, 2};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operand   = 32'hDEAD_BEEF;
        shamt     = 5'd7;
        op        = 2'b01;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].s, i % 3, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held in DONE, extra requests ignored, including on the handshake edge.
        in_valid = 1'b1;
        op       = 2'b00;
        operand  = 32'h0000_000F;
        shamt    = 5'd4;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("bp_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 2);
            operand  = 32'hAAAA_5555;
            shamt    = 5'd0;
            @(posedge clock); #1;
            check("bp_result", result, 32'h0000_00F0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_not_accepted", result, 32'h0000_00F0);
        $display("backpressure sequence result=%h", result);

        // Reset taken during SHIFT discards the operation.
        in_valid = 1'b1;
        op       = 2'b10;
        operand  = 32'hF000_0000;
        shamt    = 5'd20;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", result, 32'd0);
        repeat (12) @(posedge clock);
        #1;
        check("mid_rst_no_emit", 32'(out_valid), 32'd0);
        $display("reset mid-op sequence result=%h", result);
        run_op(2'b10, 32'hF000_0000, 5'd20, 0, res, lat);
        check("mid_fresh_result", res, 32'hFFFF_FF00);
        check("mid_fresh_latency", 32'(lat), 32'd11);

        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            run_op(ro, ra, rs, $urandom_range(0, 3), res, lat);
            check("rand_result", res, ref_model(ro, ra, rs));
            check("rand_latency", 32'(lat), 32'(1 + (int'(rs) + 1) / 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
Multi-cycle 32-bit shift unit for the ALU, used for long-latency shift operations.
- Applies at most 2 bit positions per cycle, in either direction, using one shared combinational step stage.
- Covers what the combinational 2-bit stage does not: logical right shift and rotate right, alongside left and arithmetic right.
- Operands enter through a valid/ready request handshake; results leave through a valid/ready response handshake.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- operand  input  WIDTH  value to shift.
- shamt  input  SHAMT_W  shift amount, 0..31.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result when out_valid & out_ready.
- result  output  WIDTH  shifted value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, result register=0, remaining=0, op register=00. Outputs after reset: in_ready=1, out_valid=0, busy=0, result=0.
- Reset taken mid-operation (SHIFT or DONE) discards the operation and applies the same values; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
- IDLE, on accept (in_valid & in_ready):
  - Register operand into result, shamt into remaining, and op.
  - Next state is DONE if shamt==0, otherwise SHIFT.
  - Without accept, stay in IDLE.
- SHIFT, one step per cycle:
  - remaining>=2: shift result by 2, remaining -= 2.
  - remaining==1: shift result by 1, remaining = 0.
  - When remaining reaches 0 on this edge, next state is DONE.
- Step semantics for a shift of k (1 or 2):
  - SLL: zeros fill the low k bits.
  - SRL: zeros fill the high k bits.
  - SRA: result[31] fills the high k bits.
  - ROR: bits shifted out of the LSBs re-enter at the MSBs.
- DONE:
  - result is held stable while out_ready==0.
  - On out_valid & out_ready, next state is IDLE.
  - A new request cannot be accepted in the same cycle as the DONE handshake.
- Latency, accept edge to out_valid visible: 1 + ceil(shamt/2) cycles.
  - shamt=0 gives 1 cycle; shamt=31 gives 17 cycles.
- Throughput: one operation per (latency + 1) cycles minimum, when out_ready is held high.
- Input changes while busy are ignored; only the registered copies are used.
- op and shamt are unsigned, with no range error: all 32 encodings of shamt are legal.
- result is driven directly from the register; no combinational path from any input to any output except through state.

Decomposition:
- Package shifter_pkg:
  - WIDTH and SHAMT_W constants.
  - Op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - FSM state encodings S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift_step:
  - Purely combinational: inputs value[WIDTH-1:0], op, two (1 = shift by 2, 0 = shift by 1); output stepped value.
  - Instantiated once in iterative_shifter; also unit-testable on its own.
- The FSM, remaining counter and result register live in iterative_shifter.

Test Plan:
- SLL operand=0x00000001, shamt=5, out_ready=1 -> result=0x00000020; out_valid rises 4 cycles after accept; in_ready returns 1 the cycle after the handshake.
- SRA operand=0x80000000, shamt=31 -> result=0xFFFFFFFF after 17 cycles; same request with op=SRL -> result=0x00000001.
- ROR operand=0x00000001, shamt=1 -> 0x80000000 (latency 2). ROR operand=0x12345678, shamt=0 -> 0x12345678 (latency 1).
- Backpressure: SLL operand=0x0000000F, shamt=4, out_ready held 0 for 6 cycles in DONE.
  - Required: result stays 0x000000F0, out_valid stays 1, in_ready stays 0, and a second in_valid pulse is not accepted.
  - After out_ready=1 for one cycle: IDLE.
- Reset mid-op: start SRA operand=0xF0000000, shamt=20; drive reset=0 for one edge during SHIFT.
  - Required: next cycle in_ready=1, out_valid=0, busy=0, result=0.
  - A fresh request then completes correctly.
- Randomised sweep: 1000 random operand/shamt/op with random out_ready stalls -> every result matches the reference shift/rotate model and every latency equals 1+ceil(shamt/2).
